// File: rtl/reg_dump_scanner_pkg.sv
// Shared definitions for the register-file debug readers and datapath.
package reg_dump_scanner_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;

  // Scanner state encoding, kept here so other debug readers decode it the same way.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } scan_state_t;

endpackage

// File: rtl/reg_dump_scanner.sv
// Walks register-file addresses and streams (address, data) beats to a
// consumer over valid/ready. A full dump covers FIRST_ADDR..LAST_ADDR in
// ascending order; a peek returns the single register at sel_addr.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; busy low
// READ  | R_Addr settled, capture R_Data (or the snooped write) this edge
// SEND  | beat presented on out_*, held until out_ready
// DONE  | one-cycle done pulse, then back to IDLE
module reg_dump_scanner
  import reg_dump_scanner_pkg::*;
#(
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int DATA_W     = REG_DATA_W,
  parameter int FIRST_ADDR = 0,
  parameter int LAST_ADDR  = REG_COUNT - 1
) (
  input  logic              clk_Regs,
  input  logic              clk_rst,
  input  logic              start,
  input  logic              single,
  input  logic [ADDR_W-1:0] sel_addr,
  output logic [ADDR_W-1:0] R_Addr,
  input  logic [DATA_W-1:0] R_Data,
  input  logic              Reg_Write,
  input  logic [ADDR_W-1:0] W_Addr,
  input  logic [DATA_W-1:0] W_Data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);

  scan_state_t       state_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic              busy_q;
  logic              done_q;

  logic              snoop_hit;
  logic [DATA_W-1:0] cap_data_d;
  logic              handshake;

  // A write landing on the address being read wins, so the beat carries the
  // post-write value; x0 is hardwired zero and never takes the snooped data.
  always_comb begin
    snoop_hit  = Reg_Write && (W_Addr == cur_addr_q) && (W_Addr != '0);
    cap_data_d = snoop_hit ? W_Data : R_Data;
    handshake  = out_valid_q && out_ready;
  end

  // Sequencer: single registered FSM driving the read port and beat outputs.
  always_ff @(posedge clk_Regs) begin
    if (clk_rst) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      last_addr_q <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            cur_addr_q  <= single ? sel_addr : FIRST_A;
            last_addr_q <= single ? sel_addr : LAST_A;
            busy_q      <= 1'b1;
            state_q     <= ST_READ;
          end
        end
        ST_READ: begin
          out_data_q  <= cap_data_d;
          out_addr_q  <= cur_addr_q;
          out_last_q  <= (cur_addr_q == last_addr_q);
          out_valid_q <= 1'b1;
          state_q     <= ST_SEND;
        end
        ST_SEND: begin
          if (handshake) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              // Only reached below last_addr, so the increment cannot wrap.
              cur_addr_q <= cur_addr_q + ADDR_W'(1);
              state_q    <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign R_Addr    = cur_addr_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Bench for reg_dump_scanner: behavioural register-file model plus expected
// beat lists derived from the address range and register contents.
module tb_reg_dump_scanner;

  logic        clk = 1'b0;
  logic        clk_rst, start, single, Reg_Write, out_ready;
  logic [4:0]  sel_addr, R_Addr, W_Addr, out_addr;
  logic [31:0] R_Data, W_Data, out_data;
  logic        out_valid, out_last, busy, done;

  logic        s_start, s_single, s_Reg_Write, s_out_ready;
  logic [4:0]  s_sel_addr, s_R_Addr, s_W_Addr, s_out_addr;
  logic [31:0] s_R_Data, s_W_Data, s_out_data;
  logic        s_out_valid, s_out_last, s_busy, s_done;

  logic        rf_rst;
  logic [31:0] regs [32];

  int total = 0;
  int bad   = 0;

  logic [4:0]  bq_addr[$];
  logic [31:0] bq_data[$];
  logic        bq_last[$];
  logic        st_valid[$];
  logic [4:0]  st_addr[$];
  logic [31:0] st_data[$];
  int done_cnt, lat, stab_viol, b2b_viol, hs_last, done_cyc;
  logic timeout, busy_after, done_after;

  always #5 clk = ~clk;

  reg_dump_scanner dut (
    .clk_Regs(clk), .clk_rst(clk_rst), .start(start), .single(single),
    .sel_addr(sel_addr), .R_Addr(R_Addr), .R_Data(R_Data),
    .Reg_Write(Reg_Write), .W_Addr(W_Addr), .W_Data(W_Data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  reg_dump_scanner #(.FIRST_ADDR(3), .LAST_ADDR(4)) dut_small (
    .clk_Regs(clk), .clk_rst(clk_rst), .start(s_start), .single(s_single),
    .sel_addr(s_sel_addr), .R_Addr(s_R_Addr), .R_Data(s_R_Data),
    .Reg_Write(s_Reg_Write), .W_Addr(s_W_Addr), .W_Data(s_W_Data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_addr(s_out_addr),
    .out_data(s_out_data), .out_last(s_out_last), .busy(s_busy), .done(s_done)
  );

  // Register-file model: x1=1, x2=2 at reset, x0 hardwired zero.
  always @(posedge clk) begin
    if (rf_rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 1) ? 32'd1 : (i == 2) ? 32'd2 : 32'd0;
    end else if (Reg_Write && W_Addr != 5'd0) begin
      regs[W_Addr] <= W_Data;
    end
  end

  assign R_Data   = regs[R_Addr];
  assign s_R_Data = regs[s_R_Addr];

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    Reg_Write = 1'b1; W_Addr = a; W_Data = d;
    @(negedge clk);
    Reg_Write = 1'b0;
  endtask

  // Issues one request and records beats, timing and handshake-rule violations.
  task automatic run_req(input logic sgl, input logic [4:0] sel, input int stall_pct,
                         input int stall_addr, input int stall_len,
                         input logic [31:0] snoop_mask, input logic [31:0] snoop_data,
                         input logic poke0);
    int cyc, stall_left;
    logic prev_stall, prev_hs, seen_done, stalling;
    logic [4:0] pa;
    logic [31:0] pd, snooped;
    logic pl;
    bq_addr.delete(); bq_data.delete(); bq_last.delete();
    st_valid.delete(); st_addr.delete(); st_data.delete();
    done_cnt = 0; lat = -1; stab_viol = 0; b2b_viol = 0; hs_last = -10; done_cyc = -1;
    prev_stall = 1'b0; prev_hs = 1'b0; seen_done = 1'b0; stalling = 1'b0;
    pa = '0; pd = '0; pl = 1'b0; snooped = '0;
    stall_left = stall_len;
    @(negedge clk);
    start = 1'b1; single = sgl; sel_addr = sel; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; single = 1'($urandom_range(1)); sel_addr = 5'($urandom_range(31));
    cyc = 0;
    while (!seen_done && cyc < 4000) begin
      Reg_Write = 1'b0; W_Addr = 5'($urandom_range(31)); W_Data = $urandom;
      if (out_valid && lat < 0) lat = cyc + 1;
      if (prev_stall && (!out_valid || out_addr !== pa || out_data !== pd || out_last !== pl))
        stab_viol++;
      if (prev_hs && out_valid) b2b_viol++;
      if (done) begin done_cnt++; seen_done = 1'b1; done_cyc = cyc; end
      if (busy && !out_valid && !done && snoop_mask[R_Addr] && !snooped[R_Addr]) begin
        Reg_Write = 1'b1; W_Addr = R_Addr; W_Data = snoop_data; snooped[R_Addr] = 1'b1;
      end else if (poke0 && $urandom_range(1) == 1) begin
        Reg_Write = 1'b1; W_Addr = 5'd0; W_Data = $urandom;
      end
      if (!stalling && stall_left > 0 && out_valid && int'(out_addr) == stall_addr)
        stalling = 1'b1;
      if (stalling && stall_left > 0) begin
        out_ready = 1'b0; stall_left--;
        st_valid.push_back(out_valid); st_addr.push_back(out_addr); st_data.push_back(out_data);
      end else begin
        out_ready = ($urandom_range(99) >= stall_pct);
      end
      prev_stall = out_valid && !out_ready;
      prev_hs    = out_valid && out_ready;
      if (prev_hs) begin
        bq_addr.push_back(out_addr); bq_data.push_back(out_data); bq_last.push_back(out_last);
        hs_last = cyc;
      end
      pa = out_addr; pd = out_data; pl = out_last;
      @(negedge clk);
      cyc++;
    end
    timeout = !seen_done;
    Reg_Write = 1'b0; out_ready = 1'b1;
    busy_after = busy; done_after = done;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
  endtask

  task automatic test_reset;
    clk_rst = 1'b1; rf_rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (R_Addr !== 5'd0)     begin bad++; $display("FAIL reset_raddr: got %0h want 0", R_Addr); end
    total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    total++; if (out_addr !== 5'd0)   begin bad++; $display("FAIL reset_oaddr: got %0h want 0", out_addr); end
    total++; if (out_data !== 32'd0)  begin bad++; $display("FAIL reset_odata: got %0h want 0", out_data); end
    total++; if (out_last !== 1'b0)   begin bad++; $display("FAIL reset_last: got %0b want 0", out_last); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
    total++; if (s_busy !== 1'b0 || s_out_valid !== 1'b0)
      begin bad++; $display("FAIL reset_small: got busy=%0b valid=%0b want 0 0", s_busy, s_out_valid); end
    clk_rst = 1'b0; rf_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_dump;
    logic [31:0] exp;
    run_req(1'b0, 5'd0, 0, -1, 0, 32'd0, 32'd0, 1'b0);
    total++; if (timeout)         begin bad++; $display("FAIL full_timeout: got timeout want done"); end
    total++; if (lat !== 2)       begin bad++; $display("FAIL full_latency: got %0d want 2", lat); end
    total++; if (bq_addr.size() !== 32) begin bad++; $display("FAIL full_count: got %0d want 32", bq_addr.size()); end
    for (int i = 0; i < 32 && i < bq_addr.size(); i++) begin
      exp = (i == 1) ? 32'd1 : (i == 2) ? 32'd2 : 32'd0;
      total++; if (bq_addr[i] !== 5'(i)) begin bad++; $display("FAIL full_addr[%0d]: got %0d want %0d", i, bq_addr[i], i); end
      total++; if (bq_data[i] !== exp)   begin bad++; $display("FAIL full_data[%0d]: got %0h want %0h", i, bq_data[i], exp); end
      total++; if (bq_last[i] !== (i == 31)) begin bad++; $display("FAIL full_last[%0d]: got %0b want %0b", i, bq_last[i], i == 31); end
    end
    total++; if (done_cnt !== 1)  begin bad++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt); end
    total++; if (done_cyc !== hs_last + 1) begin bad++; $display("FAIL full_done_time: got %0d want %0d", done_cyc, hs_last + 1); end
    total++; if (b2b_viol !== 0)  begin bad++; $display("FAIL full_b2b: got %0d want 0", b2b_viol); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL full_busy_after: got %0b want 0", busy_after); end
  endtask

  task automatic test_single;
    run_req(1'b1, 5'd2, 0, -1, 0, 32'd0, 32'd0, 1'b0);
    total++; if (bq_addr.size() !== 1) begin bad++; $display("FAIL peek_count: got %0d want 1", bq_addr.size()); end
    if (bq_addr.size() > 0) begin
      total++; if (bq_addr[0] !== 5'd2)  begin bad++; $display("FAIL peek_addr: got %0d want 2", bq_addr[0]); end
      total++; if (bq_data[0] !== 32'd2) begin bad++; $display("FAIL peek_data: got %0h want 2", bq_data[0]); end
      total++; if (bq_last[0] !== 1'b1)  begin bad++; $display("FAIL peek_last: got %0b want 1", bq_last[0]); end
    end
    total++; if (done_cyc !== hs_last + 1) begin bad++; $display("FAIL peek_done_time: got %0d want %0d", done_cyc, hs_last + 1); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL peek_done_cnt: got %0d want 1", done_cnt); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL peek_busy_after: got %0b want 0", busy_after); end
  endtask

  task automatic test_backpressure;
    run_req(1'b0, 5'd0, 0, 1, 5, 32'd0, 32'd0, 1'b0);
    total++; if (st_valid.size() !== 5) begin bad++; $display("FAIL bp_stall_len: got %0d want 5", st_valid.size()); end
    for (int i = 0; i < st_valid.size(); i++) begin
      total++;
      if (st_valid[i] !== 1'b1 || st_addr[i] !== 5'd1 || st_data[i] !== 32'd1) begin
        bad++; $display("FAIL bp_hold[%0d]: got v=%0b a=%0d d=%0h want v=1 a=1 d=1", i, st_valid[i], st_addr[i], st_data[i]);
      end
    end
    total++; if (bq_addr.size() !== 32) begin bad++; $display("FAIL bp_count: got %0d want 32", bq_addr.size()); end
    if (bq_addr.size() > 2) begin
      total++; if (bq_addr[1] !== 5'd1 || bq_addr[2] !== 5'd2)
        begin bad++; $display("FAIL bp_resume: got %0d,%0d want 1,2", bq_addr[1], bq_addr[2]); end
    end
    total++; if (stab_viol !== 0) begin bad++; $display("FAIL bp_stable: got %0d want 0", stab_viol); end
  endtask

  task automatic test_snoop;
    run_req(1'b0, 5'd0, 0, -1, 0, 32'h0000_0021, 32'hDEADBEEF, 1'b0);
    total++; if (bq_addr.size() !== 32) begin bad++; $display("FAIL snoop_count: got %0d want 32", bq_addr.size()); end
    if (bq_addr.size() == 32) begin
      total++; if (bq_data[5] !== 32'hDEADBEEF) begin bad++; $display("FAIL snoop_hit: got %0h want deadbeef", bq_data[5]); end
      total++; if (bq_data[0] !== 32'd0) begin bad++; $display("FAIL snoop_x0: got %0h want 0", bq_data[0]); end
      total++; if (bq_data[4] !== 32'd0 || bq_data[6] !== 32'd0)
        begin bad++; $display("FAIL snoop_neighbours: got %0h,%0h want 0,0", bq_data[4], bq_data[6]); end
    end
  endtask

  task automatic test_abort;
    int cyc, viol;
    logic [4:0] seen[$];
    out_ready = 1'b1;
    @(negedge clk); start = 1'b1; single = 1'b0;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(out_valid && out_addr == 5'd10) && cyc < 200) begin
      start = (cyc == 3 || cyc == 8);
      if (out_valid && out_ready) seen.push_back(out_addr);
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    total++; if (cyc >= 200) begin bad++; $display("FAIL abort_reach10: got timeout want beat 10"); end
    viol = 0;
    for (int i = 0; i < seen.size(); i++) if (seen[i] !== 5'(i)) viol++;
    total++; if (seen.size() !== 10 || viol !== 0)
      begin bad++; $display("FAIL abort_ignore_start: got %0d beats %0d misordered want 10 0", seen.size(), viol); end
    clk_rst = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || R_Addr !== 5'd0 || done !== 1'b0)
      begin bad++; $display("FAIL abort_state: got v=%0b b=%0b ra=%0d d=%0b want 0 0 0 0", out_valid, busy, R_Addr, done); end
    clk_rst = 1'b0;
    viol = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy || out_valid) viol++;
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", viol); end
    run_req(1'b0, 5'd0, 30, -1, 0, 32'd0, 32'd0, 1'b0);
    total++; if (bq_addr.size() !== 32 || (bq_addr.size() > 0 && bq_addr[0] !== 5'd0))
      begin bad++; $display("FAIL abort_restart: got %0d beats want 32 from addr 0", bq_addr.size()); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL abort_restart_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_small_range;
    logic [4:0]  a[$];
    logic [31:0] d[$];
    logic        l[$];
    int dc;
    logic [31:0] v3, v4;
    v3 = $urandom; v4 = $urandom;
    write_reg(5'd3, v3);
    write_reg(5'd4, v4);
    dc = 0;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (s_done) dc++;
      s_out_ready = 1'($urandom_range(1));
      if (s_out_valid && s_out_ready) begin a.push_back(s_out_addr); d.push_back(s_out_data); l.push_back(s_out_last); end
      @(negedge clk);
    end
    s_out_ready = 1'b1;
    total++; if (a.size() !== 2) begin bad++; $display("FAIL small_count: got %0d want 2", a.size()); end
    if (a.size() == 2) begin
      total++; if (a[0] !== 5'd3 || d[0] !== v3 || l[0] !== 1'b0)
        begin bad++; $display("FAIL small_beat0: got a=%0d d=%0h l=%0b want a=3 d=%0h l=0", a[0], d[0], l[0], v3); end
      total++; if (a[1] !== 5'd4 || d[1] !== v4 || l[1] !== 1'b1)
        begin bad++; $display("FAIL small_beat1: got a=%0d d=%0h l=%0b want a=4 d=%0h l=1", a[1], d[1], l[1], v4); end
    end
    total++; if (dc !== 1 || s_busy !== 1'b0) begin bad++; $display("FAIL small_done: got done=%0d busy=%0b want 1 0", dc, s_busy); end
  endtask

  task automatic test_random;
    logic sgl;
    logic [4:0] sel;
    logic [31:0] mask, sd;
    int nexp, errs;
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(6, 1)) write_reg(5'($urandom_range(31)), $urandom);
      sgl = 1'($urandom_range(1)); sel = 5'($urandom_range(31));
      mask = $urandom; sd = $urandom;
      run_req(sgl, sel, $urandom_range(70), -1, 0, mask, sd, 1'b1);
      nexp = sgl ? 1 : 32;
      total++; if (bq_addr.size() !== nexp) begin bad++; $display("FAIL rnd%0d_count: got %0d want %0d", it, bq_addr.size(), nexp); end
      errs = 0;
      for (int i = 0; i < nexp && i < bq_addr.size(); i++) begin
        if (bq_addr[i] !== (sgl ? sel : 5'(i))) errs++;
        else if (bq_data[i] !== regs[bq_addr[i]]) errs++;
        else if (bq_last[i] !== (i == nexp - 1)) errs++;
      end
      total++; if (errs !== 0) begin bad++; $display("FAIL rnd%0d_beats: got %0d wrong beats want 0", it, errs); end
      total++; if (done_cnt !== 1 || busy_after !== 1'b0)
        begin bad++; $display("FAIL rnd%0d_done: got done=%0d busy=%0b want 1 0", it, done_cnt, busy_after); end
      total++; if (stab_viol !== 0 || b2b_viol !== 0)
        begin bad++; $display("FAIL rnd%0d_handshake: got stab=%0d b2b=%0d want 0 0", it, stab_viol, b2b_viol); end
    end
  endtask

  initial begin
    clk_rst = 1'b1; rf_rst = 1'b1; start = 1'b0; single = 1'b0; sel_addr = '0;
    Reg_Write = 1'b0; W_Addr = '0; W_Data = '0; out_ready = 1'b1;
    s_start = 1'b0; s_single = 1'b0; s_sel_addr = '0; s_Reg_Write = 1'b0;
    s_W_Addr = '0; s_W_Data = '0; s_out_ready = 1'b1;
    test_reset();
    test_full_dump();
    test_single();
    test_backpressure();
    test_snoop();
    test_abort();
    test_small_range();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
